// File: rtl/torque_bar_display.sv
// torque_bar_display
//   Drives two LED bar graphs (left and right motor) from the registered drive
//   command. Each bar is a reverse field, a centre marker and a forward field.
//   The displayed position ramps one segment per step tick toward its target,
//   and the centre marker blinks while the drive is disabled.
//
// Ports
//   clk        system clock
//   rst_n      asynchronous active-low reset
//   enable     drive enabled
//   direc      00 forward, 01 reverse, 10 turn left, 11 turn right
//   torque     commanded torque level (TQ_W bits)
//   left_led   left bar: [SEG] centre, [SEG-1:0] forward, [2*SEG:SEG+1] reverse
//   right_led  right bar, same layout
//   settled    both displayed positions equal their targets

module torque_bar_display #(
  parameter int SEG          = 4,
  parameter int TQ_W         = 2,
  parameter int STEP_CYCLES  = 2500000,
  parameter int BLINK_CYCLES = 12500000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic [1:0]        direc,
  input  logic [TQ_W-1:0]   torque,
  output logic [2*SEG:0]    left_led,
  output logic [2*SEG:0]    right_led,
  output logic              settled
);

  localparam int TQ_MAX = 2**TQ_W - 1;
  localparam int LW     = 2*SEG + 1;
  // signed position, range -SEG..+SEG
  localparam int PW     = $clog2(SEG + 1) + 1;
  // holds TQ_MAX*SEG + TQ_MAX without overflow
  localparam int FW     = TQ_W + $clog2(SEG + 1) + 1;
  localparam int SW     = (STEP_CYCLES  > 1) ? $clog2(STEP_CYCLES)  : 1;
  localparam int BW     = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;

  // Round-up scaling of torque to segment count: 0 -> 0, TQ_MAX -> SEG.
  function automatic logic signed [PW-1:0] fill(input logic [TQ_W-1:0] x);
    logic [FW-1:0] num;
    logic [FW-1:0] quo;
    num = FW'(x) * FW'(SEG) + FW'(TQ_MAX - 1);
    quo = num / FW'(TQ_MAX);
    return $signed(PW'(quo));
  endfunction

  function automatic logic signed [PW-1:0] step_toward(
    input logic signed [PW-1:0] p,
    input logic signed [PW-1:0] t
  );
    if (p < t)      return p + PW'(1);
    else if (p > t) return p - PW'(1);
    else            return p;
  endfunction

  function automatic logic [LW-1:0] bar(
    input logic signed [PW-1:0] p,
    input logic                 centre
  );
    logic [LW-1:0] b;
    logic [PW-1:0] mag;
    b   = '0;
    mag = p[PW-1] ? PW'(-p) : PW'(p);
    if (p == '0) begin
      b[SEG] = centre;
    end else begin
      for (int i = 0; i < SEG; i++) begin
        if (PW'(i) < mag) begin
          if (p[PW-1]) b[SEG+1+i] = 1'b1;
          else         b[i]       = 1'b1;
        end
      end
    end
    return b;
  endfunction

  logic              en_q,        en_d;
  logic [1:0]        direc_q,     direc_d;
  logic [TQ_W-1:0]   torque_q,    torque_d;
  logic [SW-1:0]     pre_q,       pre_d;
  logic [BW-1:0]     blink_cnt_q, blink_cnt_d;
  logic              blink_ph_q,  blink_ph_d;
  logic signed [PW-1:0] pos_l_q,  pos_l_d;
  logic signed [PW-1:0] pos_r_q,  pos_r_d;
  logic [LW-1:0]     left_led_q,  left_led_d;
  logic [LW-1:0]     right_led_q, right_led_d;
  logic              settled_q,   settled_d;

  logic                 tick;
  logic                 centre;
  logic signed [PW-1:0] f_full, f_half;
  logic signed [PW-1:0] tgt_l, tgt_r;

  always_comb begin
    en_d     = enable;
    direc_d  = direc;
    torque_d = torque;

    // free-running prescaler, never restarted by input changes
    tick  = (pre_q == SW'(STEP_CYCLES - 1));
    pre_d = tick ? '0 : pre_q + SW'(1);

    // blink timebase only runs while disabled so the first "on" lands a
    // full half-period after enable falls
    blink_cnt_d = '0;
    blink_ph_d  = 1'b0;
    if (!en_q) begin
      if (blink_cnt_q == BW'(BLINK_CYCLES - 1)) begin
        blink_cnt_d = '0;
        blink_ph_d  = ~blink_ph_q;
      end else begin
        blink_cnt_d = blink_cnt_q + BW'(1);
        blink_ph_d  = blink_ph_q;
      end
    end

    f_full = fill(torque_q);
    f_half = fill(torque_q >> 1);
    tgt_l  = '0;
    tgt_r  = '0;
    if (en_q) begin
      case (direc_q)
        2'b00: begin tgt_l = f_full;  tgt_r = f_full;  end
        2'b01: begin tgt_l = -f_full; tgt_r = -f_full; end
        2'b10: begin tgt_l = f_half;  tgt_r = f_full;  end
        default: begin tgt_l = f_full; tgt_r = f_half; end
      endcase
    end

    pos_l_d = tick ? step_toward(pos_l_q, tgt_l) : pos_l_q;
    pos_r_d = tick ? step_toward(pos_r_q, tgt_r) : pos_r_q;

    centre      = en_q | blink_ph_q;
    left_led_d  = bar(pos_l_q, centre);
    right_led_d = bar(pos_r_q, centre);
    settled_d   = (pos_l_q == tgt_l) && (pos_r_q == tgt_r);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_q        <= 1'b0;
      direc_q     <= '0;
      torque_q    <= '0;
      pre_q       <= '0;
      blink_cnt_q <= '0;
      blink_ph_q  <= 1'b0;
      pos_l_q     <= '0;
      pos_r_q     <= '0;
      left_led_q  <= '0;
      right_led_q <= '0;
      settled_q   <= 1'b1;
    end else begin
      en_q        <= en_d;
      direc_q     <= direc_d;
      torque_q    <= torque_d;
      pre_q       <= pre_d;
      blink_cnt_q <= blink_cnt_d;
      blink_ph_q  <= blink_ph_d;
      pos_l_q     <= pos_l_d;
      pos_r_q     <= pos_r_d;
      left_led_q  <= left_led_d;
      right_led_q <= right_led_d;
      settled_q   <= settled_d;
    end
  end

  assign left_led  = left_led_q;
  assign right_led = right_led_q;
  assign settled   = settled_q;

endmodule

// File: tb/tb_torque_bar_display.sv
// Directed bench for torque_bar_display with SEG=4, TQ_W=2, STEP_CYCLES=4,
// BLINK_CYCLES=8. Outputs are sampled on the falling clock edge.

module tb_torque_bar_display;

  localparam int SEG = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       enable;
  logic [1:0] direc;
  logic [1:0] torque;
  logic [8:0] left_led;
  logic [8:0] right_led;
  logic       settled;

  int n_assert = 0;
  int n_fail   = 0;

  torque_bar_display #(
    .SEG(4), .TQ_W(2), .STEP_CYCLES(4), .BLINK_CYCLES(8)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .direc(direc), .torque(torque),
    .left_led(left_led), .right_led(right_led), .settled(settled)
  );

  always #5 clk = ~clk;

  task automatic check(input logic [31:0] obs, input logic [31:0] exp, input string tag);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Wait (bounded) for either bar to change; dt is falling edges elapsed.
  task automatic wait_change(output logic [8:0] vl, output logic [8:0] vr,
                             output int dt, input string tag);
    logic [8:0] pl, pr;
    logic       got;
    pl  = left_led;
    pr  = right_led;
    got = 1'b0;
    dt  = 0;
    for (int i = 1; i <= 24; i++) begin
      @(negedge clk);
      if (left_led !== pl || right_led !== pr) begin
        got = 1'b1;
        dt  = i;
        break;
      end
    end
    check(32'(got), 32'd1, {tag, "_change"});
    vl = left_led;
    vr = right_led;
  endtask

  task automatic step(input logic [8:0] el, input logic [8:0] er, input int edt,
                      input logic es, input string tag);
    logic [8:0] vl, vr;
    int dt;
    wait_change(vl, vr, dt, tag);
    check(32'(vl), 32'(el), {tag, "_left"});
    check(32'(vr), 32'(er), {tag, "_right"});
    check(32'(settled), 32'(es), {tag, "_settled"});
    if (edt != 0) check(32'(dt), 32'(edt), {tag, "_interval"});
  endtask

  task automatic reset_with(input logic en, input logic [1:0] d, input logic [1:0] t,
                            input string tag);
    @(negedge clk);
    rst_n  = 1'b0;
    enable = en;
    direc  = d;
    torque = t;
    #1;
    check(32'(left_led),  32'h0, {tag, "_left"});
    check(32'(right_led), 32'h0, {tag, "_right"});
    check(32'(settled),   32'h1, {tag, "_settled"});
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [8:0] seq_rev [8];
    logic [8:0] seq_fwd [8];
    logic [8:0] vl, vr;
    int dt;
    int rise;

    rst_n  = 1'b0;
    enable = 1'b0;
    direc  = 2'b00;
    torque = 2'd0;
    repeat (3) @(negedge clk);
    check(32'(left_led),  32'h0, "reset_left");
    check(32'(right_led), 32'h0, "reset_right");
    check(32'(settled),   32'h1, "reset_settled");

    // Scenario 1: disabled idle, centre blinks
    rst_n = 1'b1;
    @(negedge clk);
    check(32'(left_led),  32'h0, "idle_left");
    check(32'(right_led), 32'h0, "idle_right");
    check(32'(settled),   32'h1, "idle_settled");
    rise = 0;
    for (int i = 2; i <= 20; i++) begin
      @(negedge clk);
      if (left_led[SEG] === 1'b1) begin
        rise = i;
        break;
      end
    end
    check(32'(rise >= 8 && rise <= 9), 32'd1, "blink_first_rise");
    check(32'(right_led), 32'h010, "blink_first_right");
    step(9'h000, 9'h000, 8, 1'b1, "blink_fall");
    step(9'h010, 9'h010, 8, 1'b1, "blink_rise");

    // Scenario 2: forward full ramp
    enable = 1'b1;
    direc  = 2'b00;
    torque = 2'd3;
    step(9'h001, 9'h001, 0, 1'b0, "fwd1");
    step(9'h003, 9'h003, 4, 1'b0, "fwd2");
    step(9'h007, 9'h007, 4, 1'b0, "fwd3");
    step(9'h00F, 9'h00F, 4, 1'b1, "fwd4");

    // Scenario 3: reversal passes through centre, then back again
    seq_rev = '{9'h007, 9'h003, 9'h001, 9'h010, 9'h020, 9'h060, 9'h0E0, 9'h1E0};
    direc = 2'b01;
    for (int i = 0; i < 8; i++)
      step(seq_rev[i], seq_rev[i], (i == 0) ? 0 : 4, (i == 7), "rev");
    seq_fwd = '{9'h0E0, 9'h060, 9'h020, 9'h010, 9'h001, 9'h003, 9'h007, 9'h00F};
    direc = 2'b00;
    for (int i = 0; i < 8; i++)
      step(seq_fwd[i], seq_fwd[i], (i == 0) ? 0 : 4, (i == 7), "refwd");

    // Scenario 5: disable from forward full, ramp down then blink
    enable = 1'b0;
    step(9'h007, 9'h007, 0, 1'b0, "off1");
    step(9'h003, 9'h003, 4, 1'b0, "off2");
    step(9'h001, 9'h001, 4, 1'b0, "off3");
    wait_change(vl, vr, dt, "off_zero");
    check(32'(vl == 9'h000 || vl == 9'h010), 32'd1, "off_zero_left");
    check(32'(vr), 32'(vl), "off_zero_right");
    check(32'(dt), 32'd4, "off_zero_interval");
    check(32'(settled), 32'd1, "off_zero_settled");
    step(vl ^ 9'h010, vl ^ 9'h010, 0, 1'b1, "off_blink_a");
    step(vl,          vl,          8, 1'b1, "off_blink_b");
    step(vl ^ 9'h010, vl ^ 9'h010, 8, 1'b1, "off_blink_c");

    // Scenario 6: async reset in the middle of a forward ramp
    reset_with(1'b1, 2'b00, 2'd3, "rst_a");
    step(9'h010, 9'h010, 0, 1'b0, "r6_centre");
    step(9'h001, 9'h001, 0, 1'b0, "r6_1");
    step(9'h003, 9'h003, 4, 1'b0, "r6_2");
    #2;
    rst_n = 1'b0;
    #1;
    check(32'(left_led),  32'h0, "async_left");
    check(32'(right_led), 32'h0, "async_right");
    check(32'(settled),   32'h1, "async_settled");
    @(negedge clk);
    rst_n = 1'b1;
    step(9'h010, 9'h010, 0, 1'b0, "r6b_centre");
    step(9'h001, 9'h001, 0, 1'b0, "r6b_1");
    step(9'h003, 9'h003, 4, 1'b0, "r6b_2");
    step(9'h007, 9'h007, 4, 1'b0, "r6b_3");
    step(9'h00F, 9'h00F, 4, 1'b1, "r6b_4");

    // Scenario 4: turn left from rest
    reset_with(1'b1, 2'b10, 2'd3, "rst_b");
    step(9'h010, 9'h010, 0, 1'b0, "tl_centre");
    step(9'h001, 9'h001, 0, 1'b0, "tl_1");
    step(9'h003, 9'h003, 4, 1'b0, "tl_2");
    step(9'h003, 9'h007, 4, 1'b0, "tl_3");
    step(9'h003, 9'h00F, 4, 1'b1, "tl_4");

    // Turn right at torque 2: left fill(2)=3, right fill(1)=2
    direc  = 2'b11;
    torque = 2'd2;
    step(9'h007, 9'h007, 0, 1'b0, "tr_1");
    step(9'h007, 9'h003, 4, 1'b1, "tr_2");

    // Forward torque 1 -> fill(1)=2, then torque 0 -> 0
    direc  = 2'b00;
    torque = 2'd1;
    step(9'h003, 9'h003, 0, 1'b1, "t1");
    torque = 2'd0;
    step(9'h001, 9'h001, 0, 1'b0, "t0_1");
    step(9'h010, 9'h010, 4, 1'b1, "t0_2");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/torque_bar_display.md
Name: torque_bar_display

Overview:
Parametrised successor of the dual-motor torque LED display. It drives a left and a right LED bar graph from the drive command: direction, torque level and enable. Each bar has a reverse field, a centre marker and a forward field. The displayed level ramps one segment per step tick rather than jumping, and the centre marker blinks while the drive is disabled. It sits between the drive-command logic and the board LEDR pins (left bar on the upper LEDs, right bar on the lower LEDs).

Parameters:
SEG, 4, LEDs per forward/reverse field; each bar is 2*SEG+1 bits wide
TQ_W, 2, torque input width; TQ_MAX = 2**TQ_W-1
STEP_CYCLES, 2500000, clocks per ramp step tick (>=1)
BLINK_CYCLES, 12500000, clocks per blink half-period (>=1)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
enable  in  1  drive enabled
direc  in  2  00 forward, 01 reverse, 10 turn left, 11 turn right
torque  in  TQ_W  commanded torque level
left_led  out  2*SEG+1  left motor bar; bit SEG is the centre, bits SEG-1..0 forward, bits 2*SEG..SEG+1 reverse
right_led  out  2*SEG+1  right motor bar, same layout
settled  out  1  both displayed positions equal their targets

Behaviour:
- Reset is asynchronous and active-low, and takes effect immediately, including mid-ramp. All of the following clear to 0: input registers, prescaler, blink counter, blink phase, both positions, left_led and right_led. settled resets to 1.
- Input stage: enable, direc and torque are registered every clk. All later logic uses only the registered copies.
- Fill function: fill(x) = (x*SEG + TQ_MAX-1) / TQ_MAX, using unsigned integer division. The intermediate must be wide enough for TQ_MAX*SEG+TQ_MAX with no overflow. The result is always in 0..SEG; x=0 gives 0 and x=TQ_MAX gives SEG.
- Targets are signed, in the range -SEG..+SEG.
  - enable=0: both targets are 0.
  - 00: both targets are +fill(torque).
  - 01: both targets are -fill(torque).
  - 10: left target is +fill(torque>>1), right target is +fill(torque).
  - 11: left target is +fill(torque), right target is +fill(torque>>1).
- Prescaler: counts 0..STEP_CYCLES-1 and wraps. tick is asserted for one clk when the count equals STEP_CYCLES-1. The prescaler runs freely and is never reset by input changes.
- Position update: on tick, each side's position p moves exactly 1 toward its target. If p equals the target, p holds.
  - A direction reversal therefore passes through 0, and takes |p_old|+|target| ticks in total.
  - A target change between ticks only affects the next tick.
- LED mapping, registered from p with 1 clk latency after the p update:
  - p>0: bits p-1..0 are lit.
  - p<0: bits SEG+|p|..SEG+1 are lit.
  - p=0: bit SEG (centre) is lit if enable=1; if enable=0 it follows blink phase.
  - All other bits are 0.
- Blink: the counter is held at 0 and the phase at 0 while registered enable=1. While enable=0, the phase toggles every BLINK_CYCLES clocks. The first toggle to "on" therefore occurs BLINK_CYCLES clocks after enable falls. Blinking is shown only once p=0 on that side.
- settled: registered; equals (p_left==target_left && p_right==target_right). It is 0 while either side is still ramping.
- Simultaneous tick and input change: the tick uses the target derived from the registered inputs present in that cycle.

Test Plan:
Parameters for all scenarios: SEG=4, TQ_W=2, STEP_CYCLES=4, BLINK_CYCLES=8.

1. Hold rst_n=0, then release with enable=0 -> left_led=right_led=9'h000 and settled=1. The centre bit first rises 8 clocks after release and then toggles every 8 clocks.
2. Drive enable=1, direc=00, torque=3 from rest -> on successive ticks, 4 clocks apart, both bars show 9'h001, 9'h003, 9'h007, 9'h00F. settled is 0 during the ramp and 1 once 9'h00F is shown.
3. From forward full, drive direc=01, torque=3 -> both bars step through 9'h007, 9'h003, 9'h001, 9'h010 (centre), 9'h020, 9'h060, 9'h0E0, 9'h1E0. That is 8 ticks, with no skipped step.
4. Drive direc=10, torque=3 from rest -> left settles at 9'h003 after 2 ticks and right settles at 9'h00F after 4 ticks. settled rises only after the 4th tick.
5. Drive enable 1->0 from forward full -> both bars ramp down to 9'h000 or 9'h010. Once at 0, the bars alternate 9'h010 and 9'h000 every 8 clocks.
6. Pulse rst_n=0 mid-ramp in scenario 2 -> outputs are 9'h000 in the same cycle without waiting for clk. After release, the ramp restarts from position 0.
